ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu.sv | 124 ++++++++++++
 tb/tb_ifu.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding memory request, holds each fetched
// instruction until the decoder accepts it, and tracks EXU redirects.
module ifu #(
    parameter int unsigned             RegWidth = 64,
    parameter int unsigned             INSTWide = 32,
    parameter logic [RegWidth-1:0]     RESET_PC = 64'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [RegWidth-1:0] imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSTWide-1:0] imem_rsp_data,
    output logic                ifu_valid,
    input  logic                idu_ready,
    output logic [INSTWide-1:0] id_inst,
    output logic [RegWidth-1:0] id_pc,
    input  logic                redirect_valid,
    input  logic [RegWidth-1:0] redirect_pc,
    output logic [63:0]         fetch_cnt
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [RegWidth-1:0] pc, pc_nxt;
    logic                drop, drop_nxt;
    logic                latch_rsp;
    logic                accept;

    function automatic logic [RegWidth-1:0] align_pc(input logic [RegWidth-1:0] a);
        return a & ~RegWidth'(3);
    endfunction

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drop_nxt       = drop;
        latch_rsp      = 1'b0;
        accept         = 1'b0;
        imem_req_valid = 1'b0;
        ifu_valid      = 1'b0;
        case (state)
            ST_REQ: begin
                imem_req_valid = 1'b1;
                if (redirect_valid) begin
                    pc_nxt = align_pc(redirect_pc);
                end
                if (imem_req_ready) begin
                    // A redirect in the accept cycle leaves the old-pc request
                    // in flight; its response must be thrown away.
                    state_nxt = ST_WAIT;
                    drop_nxt  = redirect_valid;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt = ST_REQ;
                    drop_nxt  = 1'b0;
                    if (redirect_valid) begin
                        pc_nxt = align_pc(redirect_pc);
                    end else if (!drop) begin
                        latch_rsp = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_nxt   = align_pc(redirect_pc);
                    drop_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                ifu_valid = 1'b1;
                if (redirect_valid) begin
                    pc_nxt    = align_pc(redirect_pc);
                    state_nxt = ST_REQ;
                end else if (idu_ready) begin
                    pc_nxt    = pc + RegWidth'(4);
                    accept    = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_REQ;
                drop_nxt  = 1'b0;
            end
        endcase
    end

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            drop      <= 1'b0;
            id_inst   <= '0;
            id_pc     <= '0;
            fetch_cnt <= '0;
        end else begin
            pc   <= pc_nxt;
            drop <= drop_nxt;
            if (latch_rsp) begin
                id_inst <= imem_rsp_data;
                id_pc   <= pc;
            end
            if (accept) begin
                fetch_cnt <= fetch_cnt + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios followed by randomized traffic, all checked
// against a transaction-level model of the fetch unit.
module tb_ifu;

    localparam int unsigned RW = 64;
    localparam int unsigned IW = 32;

    logic          clk;
    logic          rst;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [RW-1:0] imem_addr;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;
    logic          ifu_valid;
    logic          idu_ready;
    logic [IW-1:0] id_inst;
    logic [RW-1:0] id_pc;
    logic          redirect_valid;
    logic [RW-1:0] redirect_pc;
    logic [63:0]   fetch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ifu_valid      (ifu_valid),
        .idu_ready      (idu_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_cnt      (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: which phase of a fetch transaction we are in.
    bit          m_in_flight;
    bit          m_have_inst;
    bit          m_stale;
    logic [63:0] m_pc;
    logic [31:0] m_inst;
    logic [63:0] m_ipc;
    logic [63:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_flight = 0;
        m_have_inst = 0;
        m_stale     = 0;
        m_pc        = 64'h8000_0000;
        m_inst      = '0;
        m_ipc       = '0;
        m_cnt       = '0;
    endtask

    task automatic check_all();
        check("req_valid", {63'd0, imem_req_valid}, {63'd0, !m_in_flight && !m_have_inst});
        check("imem_addr", imem_addr, m_pc);
        check("ifu_valid", {63'd0, ifu_valid}, {63'd0, m_have_inst});
        check("id_inst", {32'd0, id_inst}, {32'd0, m_inst});
        check("id_pc", id_pc, m_ipc);
        check("fetch_cnt", fetch_cnt, m_cnt);
    endtask

    // Called at a falling edge: check, drive one cycle of inputs, advance model.
    task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rd,
                         input bit ir, input bit xv, input logic [63:0] xpc);
        logic [63:0] tgt;
        check_all();
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        idu_ready      = ir;
        redirect_valid = xv;
        redirect_pc    = xpc;
        tgt = {xpc[63:2], 2'b00};
        if (m_have_inst) begin
            if (xv) begin
                m_pc = tgt;
                m_have_inst = 0;
            end else if (ir) begin
                m_pc = m_pc + 64'd4;
                m_cnt = m_cnt + 64'd1;
                m_have_inst = 0;
            end
        end else if (m_in_flight) begin
            if (rv) begin
                m_in_flight = 0;
                if (xv) m_pc = tgt;
                else if (!m_stale) begin
                    m_inst = rd;
                    m_ipc = m_pc;
                    m_have_inst = 1;
                end
                m_stale = 0;
            end else if (xv) begin
                m_pc = tgt;
                m_stale = 1;
            end
        end else begin
            if (rdy) begin
                m_in_flight = 1;
                m_stale = xv;
            end
            if (xv) m_pc = tgt;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(0, 0, 32'h0, 0, 0, 64'h0);
    endtask

    initial begin
        rst = 1'b0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        idu_ready = 0; redirect_valid = 0; redirect_pc = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst = 1'b1;
        @(negedge clk);

        // Basic fetch and accept.
        cycle(1, 0, 32'h0, 0, 0, 64'h0);
        cycle(0, 1, 32'h0000_0013, 0, 0, 64'h0);
        check("t33_pc", id_pc, 64'h8000_0000);
        check("t33_inst", {32'd0, id_inst}, 64'h13);
        cycle(0, 0, 32'h0, 1, 0, 64'h0);
        check("t33_addr", imem_addr, 64'h8000_0004);
        check("t33_cnt", fetch_cnt, 64'd1);

        // Backpressure from IDU for 5 cycles.
        cycle(1, 0, 32'h0, 0, 0, 64'h0);
        cycle(0, 1, 32'h1234_5678, 0, 0, 64'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, 32'hFFFF_FFFF, 0, 0, 64'h0);
            check("t34_vld", {63'd0, ifu_valid}, 64'd1);
            check("t34_inst", {32'd0, id_inst}, 64'h1234_5678);
            check("t34_pc", id_pc, 64'h8000_0004);
            check("t34_req", {63'd0, imem_req_valid}, 64'd0);
        end
        cycle(0, 0, 32'h0, 1, 0, 64'h0);
        check("t34_cnt", fetch_cnt, 64'd2);

        // Redirect while waiting; late response is dropped.
        cycle(1, 0, 32'h0, 0, 0, 64'h0);
        cycle(0, 0, 32'h0, 0, 1, 64'h8000_0100);
        idle();
        cycle(0, 1, 32'hDEAD_BEEF, 0, 0, 64'h0);
        check("t35_vld", {63'd0, ifu_valid}, 64'd0);
        check("t35_addr", imem_addr, 64'h8000_0100);
        check("t35_req", {63'd0, imem_req_valid}, 64'd1);

        // Redirect beats idu_ready in HOLD; target low bits cleared.
        cycle(1, 0, 32'h0, 0, 0, 64'h0);
        cycle(0, 1, 32'h0000_0093, 0, 0, 64'h0);
        cycle(0, 0, 32'h0, 1, 1, 64'h8000_0203);
        check("t36_cnt", fetch_cnt, 64'd2);
        check("t36_addr", imem_addr, 64'h8000_0200);

        // PC wraps to zero.
        cycle(0, 0, 32'h0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1, 0, 32'h0, 0, 0, 64'h0);
        cycle(0, 1, 32'h0000_0033, 0, 0, 64'h0);
        check("t37_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(0, 0, 32'h0, 1, 0, 64'h0);
        check("t37_addr", imem_addr, 64'h0);
        check("t37_cnt", fetch_cnt, 64'd3);

        // Reset in the middle of WAIT.
        cycle(1, 0, 32'h0, 0, 0, 64'h0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("t38_addr", imem_addr, 64'h8000_0000);
        check("t38_vld", {63'd0, ifu_valid}, 64'd0);
        check("t38_cnt", fetch_cnt, 64'd0);
        check("t38_req", {63'd0, imem_req_valid}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        cycle(0, 1, 32'hCAFE_F00D, 0, 0, 64'h0);
        check("t38_ign", {63'd0, ifu_valid}, 64'd0);
        check("t38_addr2", imem_addr, 64'h8000_0000);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                               : 64'h8000_0000 + 64'($urandom_range(0, 1023));
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0, tgt);
        end
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
